hamming_tx_serializer: RTL and testbench
========================================

Name: hamming_tx_serializer

Overview:
- Downstream of the 12/8 Hamming encoder: accepts 12-bit codewords over a valid/ready handshake and transmits each as an asynchronous serial frame on a single line.
- Frame: start bit, 12 codeword bits LSB first, stop bit.
- A one-word holding register lets the next codeword be accepted while the current frame shifts out, so back-to-back frames have no idle gap.

Parameters:
- CW_W, 12, codeword width in bits; must be ≥2.
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- s_data  in  CW_W  codeword from the Hamming encoder.
- s_valid  in  1  s_data valid.
- s_ready  out  1  holding register empty; word accepted on an edge where s_valid && s_ready.
- tx  out  1  serial line, registered; idles high.
- tx_busy  out  1  high while a frame is on the line (START through STOP).
- frame_done  out  1  one-cycle pulse on the last cycle of each STOP bit.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: tx=1, tx_busy=0, frame_done=0, s_ready=1, hold register empty, FSM=IDLE, all counters 0.
- s_ready is defined as ~hold_full.
  - Acceptance at edge N sets hold_full and latches s_data.
  - s_data and s_valid are ignored when s_ready=0.
- FSM states: IDLE, START, DATA, STOP (PARITY with the option). Every bit state lasts exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that restarts on each state entry.
- IDLE:
  - tx=1.
  - If hold_full: load shift register from hold, clear hold_full, go to START.
  - Word accepted at edge N → tx=0 from edge N+1. Latency is 1 cycle.
- START: tx=0, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0]; shift right at each bit boundary.
  - After bit CW_W-1, go to STOP.
- STOP: tx=1; frame_done=1 on its final cycle.
  - At the boundary, if hold_full: load the next word and go straight to START, so tx falls on the very next cycle.
  - Otherwise go to IDLE.
- Frame length: (CW_W+2)·CLKS_PER_BIT cycles. tx_busy is high for exactly that span per frame.
- Loading the shift register clears hold_full at the same edge. s_ready rises on the following cycle; same-edge accept-and-load does not occur.
- s_valid held high continuously with fresh data: every word is transmitted once, in order, with no loss and no duplication.
- Reset mid-frame: at the reset edge tx returns to 1 and the FSM goes to IDLE. The in-flight word and any held word are discarded, and s_ready=1 on the next cycle.
- CLKS_PER_BIT=1: each bit lasts one cycle; same rules apply.
- The bit-cycle counter width is $clog2(CLKS_PER_BIT) (minimum 1). The bit index is sized to cover CW_W-1.

Optional Feature:
- Macro: HAMMING_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of all CW_W codeword bits (even parity over data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (CW_W+3)·CLKS_PER_BIT.
- Not defined: no PARITY state and no parity logic; frame as above.

Test Plan:
- Reset then idle, 50 cycles, no s_valid → tx=1, tx_busy=0, s_ready=1, frame_done never asserted.
- CLKS_PER_BIT=4, send 12'hA5C once → tx falls 1 cycle after the accept.
  - Per-bit tx sequence: 0, then 0,0,1,1,1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles.
  - 56 busy cycles; one frame_done pulse.
- Back-to-back: s_valid held high with 12'h001, 12'hFFF, 12'h800 → three contiguous frames with no idle cycle between STOP and next START.
  - s_ready low while hold is occupied.
  - Decoded words match in order.
- Backpressure: assert s_valid with changing s_data while s_ready=0 → only words present on accepting edges are transmitted.
- Reset asserted in the middle of DATA of 12'h3C3 with a second word held → tx=1 the next cycle; neither word is transmitted; the next accepted word 12'h0F0 frames correctly.
- With HAMMING_TX_PARITY_EN, send 12'hA5C (popcount 6) then 12'h001 → parity bits 0 and 1 respectively; frames are 60 cycles each at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/hamming_tx_serializer.sv
// Serialises 12-bit Hamming codewords as start + LSB-first data + stop frames, holding one word ahead.
// Optional even-parity bit before STOP when HAMMING_TX_PARITY_EN is defined.
module hamming_tx_serializer #(
  parameter int CW_W         = 12,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW_W-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic            frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(CW_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CW_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef HAMMING_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  bidx, bidx_nxt;
  logic [CW_W-1:0]   shift, shift_nxt;
  logic [CW_W-1:0]   hold;
  logic              hold_full;
  logic              boundary, load, accept;
  logic              tx_nxt, busy_nxt, done_nxt;
`ifdef HAMMING_TX_PARITY_EN
  logic              par;
`endif

  assign s_ready  = ~hold_full;
  assign accept   = s_valid & ~hold_full;
  assign boundary = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (hold_full) begin
          state_nxt = S_START;
          load      = 1'b1;
        end
      end
      S_START: if (boundary) state_nxt = S_DATA;
      S_DATA: begin
        if (boundary && bidx == IDX_LAST) begin
`ifdef HAMMING_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef HAMMING_TX_PARITY_EN
      S_PARITY: if (boundary) state_nxt = S_STOP;
`endif
      S_STOP: begin
        // Chain straight into the next frame so there is no idle gap.
        if (boundary) begin
          if (hold_full) begin
            state_nxt = S_START;
            load      = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt   = (state == S_IDLE || boundary) ? '0 : cnt + 1'b1;
    bidx_nxt  = bidx;
    shift_nxt = shift;
    if (state == S_START) begin
      bidx_nxt = '0;
    end else if (state == S_DATA && boundary) begin
      bidx_nxt = bidx + 1'b1;
    end
    if (load) begin
      shift_nxt = hold;
    end else if (state == S_DATA && boundary) begin
      shift_nxt = shift >> 1;
    end
  end

  // Outputs are registered from next-state values so tx is glitch-free.
  always_comb begin
    tx_nxt   = 1'b1;
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
`ifdef HAMMING_TX_PARITY_EN
      S_PARITY: tx_nxt = par;
`endif
      default:  tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_STOP) && (cnt_nxt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      bidx       <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      bidx       <= bidx_nxt;
      shift      <= shift_nxt;
      tx         <= tx_nxt;
      tx_busy    <= busy_nxt;
      frame_done <= done_nxt;
      if (accept) begin
        hold <= s_data;
      end
      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
    end
  end

`ifdef HAMMING_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ^hold;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Bench for hamming_tx_serializer: accept-side scoreboard plus a cycle-exact frame monitor.
module tb_hamming_tx_serializer;
  localparam int CW  = 12;
  localparam int CPB = 4;
`ifdef HAMMING_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB = CW + 2 + PAR;
  localparam int FL = FB * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, tx, tx_busy, frame_done;

  always #5 clk = ~clk;

  hamming_tx_serializer #(.CW_W(CW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [CW-1:0] exp_q[$];
  int cyc = 0;
  int acc_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst && s_valid && s_ready) begin
      exp_q.push_back(s_data);
      acc_cnt++;
    end
  end

  // Frame monitor: expected tx per cycle comes from the word popped at frame start.
  logic          inframe = 1'b0;
  int            pos, frames = 0, last_end = 0;
  int            busy_cnt = 0, done_cnt = 0, bad_tx, busy_bad, done_bad, mb;
  logic          me, got_par = 1'b0;
  logic [CW-1:0] cur_w = '0, got_w = '0;
  int            gaps_q[$];

  always @(negedge clk) begin
    if (rst) begin
      inframe = 1'b0;
      exp_q.delete();
    end else begin
      busy_cnt += int'(tx_busy);
      done_cnt += int'(frame_done);
      if (!inframe && tx === 1'b0) begin
        inframe = 1'b1;
        pos = 0; bad_tx = 0; busy_bad = 0; done_bad = 0;
        gaps_q.push_back(cyc - last_end - 1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          cur_w = '0;
        end else begin
          cur_w = exp_q.pop_front();
        end
      end
      if (inframe) begin
        mb = pos / CPB;
        if (mb == 0) me = 1'b0;
        else if (mb <= CW) me = cur_w[mb-1];
        else me = 1'b1;
        if (!(PAR == 1 && mb == CW + 1) && tx !== me) bad_tx++;
        if (mb >= 1 && mb <= CW && pos % CPB == CPB / 2) got_w[mb-1] = tx;
        if (PAR == 1 && mb == CW + 1 && pos % CPB == CPB / 2) got_par = tx;
        if (tx_busy !== 1'b1) busy_bad++;
        if (frame_done !== (pos == FL - 1)) done_bad++;
        if (pos == FL - 1) begin
          check("frame_word", got_w, cur_w);
          check("frame_bits", bad_tx, 0);
          check("frame_busy", busy_bad, 0);
          check("frame_done_pos", done_bad, 0);
          frames++;
          inframe = 1'b0;
          last_end = cyc;
        end
        pos++;
      end else if (frame_done !== 1'b0) begin
        check("spurious_done", frame_done, 0);
      end
    end
  end

  task automatic send(input logic [CW-1:0] w);
    int t = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (s_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("send_timeout", (t < 2000), 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || inframe || tx_busy !== 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", (t < 3000), 1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [CW-1:0] w;
    logic          par;
  } vec_t;

  vec_t vecs[6];
  int   f0, idle_bad, rdy_low;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{12'hA5C, 1'b0};
    vecs[1] = '{12'h001, 1'b1};
    vecs[2] = '{12'hFFF, 1'b0};
    vecs[3] = '{12'h800, 1'b1};
    vecs[4] = '{12'h3C3, 1'b0};
    vecs[5] = '{12'h0F0, 1'b0};

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_ready", s_ready, 1);
    check("rst_done", frame_done, 0);
    rst = 1'b0;
    idle_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || s_ready !== 1'b1 || frame_done !== 1'b0) idle_bad++;
    end
    check("idle_50", idle_bad, 0);
    check("idle_frames", frames, 0);

    // Single 12'hA5C: latency, busy span, one done pulse
    busy_cnt = 0; done_cnt = 0;
    s_valid = 1'b1; s_data = 12'hA5C;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    check("lat_edge_n_tx", tx, 1);
    check("lat_edge_n_ready", s_ready, 0);
    @(negedge clk);
    check("lat_edge_n1_tx", tx, 0);
    check("ready_after_load", s_ready, 1);
    wait_done();
    check("single_busy_cycles", busy_cnt, FL);
    check("single_done_pulses", done_cnt, 1);
    check("single_frames", frames, 1);

    // Table of isolated words
    for (int i = 0; i < 6; i++) begin
      f0 = frames;
      send(vecs[i].w);
      wait_done();
      check("table_frame_count", frames, f0 + 1);
`ifdef HAMMING_TX_PARITY_EN
      check("table_parity", got_par, vecs[i].par);
`endif
    end

    // Back-to-back with s_valid held high
    f0 = frames;
    gaps_q.delete();
    send(12'h001);
    send(12'hFFF);
    check("b2b_ready_low_held", s_ready, 0);
    send(12'h800);
    wait_done();
    check("b2b_frames", frames, f0 + 3);
    check("b2b_gap1", (gaps_q.size() == 3) ? gaps_q[1] : -1, 0);
    check("b2b_gap2", (gaps_q.size() == 3) ? gaps_q[2] : -1, 0);

    // Backpressure: data changes every cycle, only accepted words go out
    f0 = frames; acc_cnt = 0; rdy_low = 0;
    s_valid = 1'b1;
    for (int k = 0; k < 3 * FL; k++) begin
      s_data = 12'h100 + CW'(k);
      @(negedge clk);
      if (s_ready === 1'b0) rdy_low++;
    end
    s_valid = 1'b0;
    wait_done();
    check("bp_ready_was_low", (rdy_low > 0), 1);
    check("bp_frames_eq_accepts", frames - f0, acc_cnt);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset in the middle of DATA with a held word
    f0 = frames;
    send(12'h3C3);
    repeat (4 * CPB) @(negedge clk);
    send(12'h0F1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_ready", s_ready, 1);
    check("midrst_busy", tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_frame", frames, f0);
    check("midrst_idle_tx", tx, 1);
    send(12'h0F0);
    wait_done();
    check("midrst_next_frame", frames, f0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
